// File: rtl/adc_oversample_filter.sv
// adc_oversample_filter: per-channel decimating averager for the channel-serial
// ADC stream; each channel has its own enable, pre-batch delay and batch size.
module adc_oversample_filter #(
    parameter int W_DATA      = 18,
    parameter int N_CHAN      = 6,
    parameter int W_CHAN      = 3,
    parameter int MAX_LOG_OVR = 10,
    parameter int W_LOG_OVR   = 4,
    parameter int W_CYC_DLY   = 16
) (
    input  logic                 clk17_in,
    input  logic                 rst_n_in,
    input  logic                 data_valid_in,
    input  logic [W_CHAN-1:0]    chan_in,
    input  logic [W_DATA-1:0]    data_in,
    input  logic                 cfg_wr_in,
    input  logic [W_CHAN-1:0]    cfg_chan_in,
    input  logic                 cfg_activate_in,
    input  logic [W_CYC_DLY-1:0] cfg_cyc_dly_in,
    input  logic [W_LOG_OVR-1:0] cfg_log_ovr_in,
    output logic                 data_valid_out,
    output logic [W_CHAN-1:0]    chan_out,
    output logic [W_DATA-1:0]    data_out
);

    localparam int W_ACC = W_DATA + MAX_LOG_OVR;
    localparam int W_SMP = MAX_LOG_OVR;

    localparam logic [W_CHAN:0]    N_CHAN_W = (W_CHAN+1)'(N_CHAN);
    localparam logic [W_LOG_OVR-1:0] LOG_MAX = W_LOG_OVR'(MAX_LOG_OVR);
    localparam logic [W_SMP:0]     ONE      = (W_SMP+1)'(1);

    typedef enum logic {
        DELAY,
        ACCUM
    } state_t;

    state_t                   state   [N_CHAN];
    logic                     active  [N_CHAN];
    logic [W_CYC_DLY-1:0]     cyc_dly [N_CHAN];
    logic [W_LOG_OVR-1:0]     log_ovr [N_CHAN];
    logic [W_CYC_DLY-1:0]     dly_cnt [N_CHAN];
    logic [W_SMP-1:0]         smp_cnt [N_CHAN];
    logic signed [W_ACC-1:0]  acc     [N_CHAN];

    logic                     wr_ok;
    logic                     chan_ok;
    logic [W_CHAN-1:0]        sel;
    logic                     smp_ok;
    logic                     in_dly;
    logic                     last;
    logic                     done;
    logic signed [W_ACC-1:0]  sum;
    logic [W_DATA-1:0]        avg;

    // Only the channel named by chan_in can advance in a given cycle.
    always_comb begin
        wr_ok   = cfg_wr_in && ({1'b0, cfg_chan_in} < N_CHAN_W);
        chan_ok = {1'b0, chan_in} < N_CHAN_W;
        sel     = chan_ok ? chan_in : '0;
        smp_ok  = data_valid_in && chan_ok && active[sel]
                  && !(wr_ok && (cfg_chan_in == chan_in));
        in_dly  = (state[sel] == DELAY) && (dly_cnt[sel] < cyc_dly[sel]);
        sum     = acc[sel] + {{MAX_LOG_OVR{data_in[W_DATA-1]}}, data_in};
        last    = ({1'b0, smp_cnt[sel]} + ONE) == (ONE << log_ovr[sel]);
        avg     = W_DATA'(sum >>> log_ovr[sel]);
        done    = smp_ok && !in_dly && last;
    end

    always_ff @(posedge clk17_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_valid_out <= 1'b0;
            chan_out       <= '0;
            data_out       <= '0;
            for (int i = 0; i < N_CHAN; i++) begin
                state[i]   <= DELAY;
                active[i]  <= 1'b0;
                cyc_dly[i] <= '0;
                log_ovr[i] <= '0;
                dly_cnt[i] <= '0;
                smp_cnt[i] <= '0;
                acc[i]     <= '0;
            end
        end else begin
            data_valid_out <= done;
            if (done) begin
                chan_out <= chan_in;
                data_out <= avg;
            end
            for (int i = 0; i < N_CHAN; i++) begin
                if (wr_ok && (cfg_chan_in == W_CHAN'(i))) begin
                    active[i]  <= cfg_activate_in;
                    cyc_dly[i] <= cfg_cyc_dly_in;
                    log_ovr[i] <= (cfg_log_ovr_in > LOG_MAX) ?
                                  LOG_MAX : cfg_log_ovr_in;
                    dly_cnt[i] <= '0;
                    smp_cnt[i] <= '0;
                    acc[i]     <= '0;
                    state[i]   <= DELAY;
                end else if (smp_ok && (chan_in == W_CHAN'(i))) begin
                    if (in_dly) begin
                        dly_cnt[i] <= dly_cnt[i] + W_CYC_DLY'(1);
                    end else if (last) begin
                        dly_cnt[i] <= '0;
                        smp_cnt[i] <= '0;
                        acc[i]     <= '0;
                        state[i]   <= DELAY;
                    end else begin
                        acc[i]     <= sum;
                        smp_cnt[i] <= smp_cnt[i] + W_SMP'(1);
                        state[i]   <= ACCUM;
                    end
                end
            end
        end
    end

endmodule
